// File: rtl/metaframe_generator.sv
// Per-lane Interlaken metaframe scheduler feeding the lane scrambler.
// Emits sync/scrambler-state/skip/diagnostic words in fixed slots, payload or idle elsewhere.
module metaframe_generator #(
    parameter int          TX_DATA_WIDTH    = 64,
    parameter int          METAFRAME_LENGTH = 2048,
    parameter logic [63:0] SYNC_WORD        = 64'h78f678f678f678f6,
    parameter logic [63:0] SKIP_WORD        = 64'h21e421e421e421e4,
    parameter logic [63:0] IDLE_WORD        = 64'h8000000000000000
) (
    input  logic                     USER_CLK,
    input  logic                     SYSTEM_RESET_N,
    input  logic [TX_DATA_WIDTH-1:0] DATA_IN,
    input  logic [1:0]               HEADER_IN,
    input  logic                     DATA_IN_VALID,
    output logic                     DATA_IN_READY,
    input  logic                     LANE_STATUS,
    input  logic                     LINK_STATUS,
    input  logic [31:0]              CRC32_IN,
    output logic [TX_DATA_WIDTH-1:0] DATA_OUT,
    output logic [1:0]               HEADER_OUT,
    output logic                     FRAME_START
);

    localparam int CW = $clog2(METAFRAME_LENGTH);

    localparam logic [CW-1:0] S_SYNC     = CW'(0);
    localparam logic [CW-1:0] S_SCRAM    = CW'(1);
    localparam logic [CW-1:0] S_SKIP     = CW'(2);
    localparam logic [CW-1:0] S_PAY_LO   = CW'(3);
    localparam logic [CW-1:0] S_PAY_HI   = CW'(METAFRAME_LENGTH - 2);
    localparam logic [CW-1:0] S_DIAG     = CW'(METAFRAME_LENGTH - 1);

    localparam logic [1:0]  HDR_CTRL   = 2'b10;
    localparam logic [63:0] SCRAM_WORD = {6'b001010, 58'h0};

    logic [CW-1:0]            slot_q;
    logic [CW-1:0]            slot_d;
    logic [TX_DATA_WIDTH-1:0] data_q;
    logic [TX_DATA_WIDTH-1:0] data_d;
    logic [1:0]               hdr_q;
    logic [1:0]               hdr_d;
    logic                     fs_q;
    logic                     fs_d;
    logic                     payload_slot;

    assign payload_slot  = (slot_q >= S_PAY_LO) && (slot_q <= S_PAY_HI);
    assign DATA_IN_READY = SYSTEM_RESET_N && payload_slot;

    assign DATA_OUT    = data_q;
    assign HEADER_OUT  = hdr_q;
    assign FRAME_START = fs_q;

    // Free-running slot counter, wrapping at the metaframe length.
    always_comb begin
        slot_d = (slot_q == S_DIAG) ? '0 : slot_q + 1'b1;
    end

    // Select the word for the current slot; payload slots fall back to idle.
    always_comb begin
        data_d = IDLE_WORD;
        hdr_d  = HDR_CTRL;
        fs_d   = 1'b0;
        unique case (slot_q)
            S_SYNC: begin
                data_d = SYNC_WORD;
                fs_d   = 1'b1;
            end
            S_SCRAM: data_d = SCRAM_WORD;
            S_SKIP:  data_d = SKIP_WORD;
            S_DIAG: begin
                data_d = {6'b011001, 24'h0, LANE_STATUS,
                          LINK_STATUS, CRC32_IN};
            end
            default: begin
                if (DATA_IN_VALID) begin
                    data_d = DATA_IN;
                    hdr_d  = HEADER_IN;
                end
            end
        endcase
    end

    // Register counter and outputs; reset abandons the current metaframe.
    always_ff @(posedge USER_CLK) begin
        if (!SYSTEM_RESET_N) begin
            slot_q <= '0;
            data_q <= '0;
            hdr_q  <= 2'b00;
            fs_q   <= 1'b0;
        end else begin
            slot_q <= slot_d;
            data_q <= data_d;
            hdr_q  <= hdr_d;
            fs_q   <= fs_d;
        end
    end

endmodule
